// File: rtl/ssd_source_select_pkg.sv
// Shared definitions for the seven-segment display path: source encodings,
// display width and the saturating conversion into the display range.
package ssd_source_select_pkg;

    localparam int DISP_W = 13;
    localparam logic [DISP_W-1:0] DISP_MAX = 13'd8191;

    typedef enum logic [1:0] {
        MODE_PC   = 2'd0,
        MODE_ALU  = 2'd1,
        MODE_INST = 2'd2,
        MODE_REG  = 2'd3
    } mode_e;

    typedef struct packed {
        logic              ovf;
        logic [DISP_W-1:0] num;
    } disp_t;

    // Unsigned clamp of a 32-bit observation value to what four digits can show.
    function automatic disp_t saturate(input logic [31:0] value);
        disp_t result;
        if (value[31:DISP_W] != '0) begin
            result.ovf = 1'b1;
            result.num = DISP_MAX;
        end else begin
            result.ovf = 1'b0;
            result.num = value[DISP_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/ssd_source_select_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debounce counter
// and a one-cycle pulse on each accepted press (release is silent).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // press is raised on the same edge the debounced level rises, so it is
    // visible for exactly the first cycle of the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ssd_source_select.sv
// Chooses one of four processor observation values for the seven-segment
// driver, samples it periodically or on a mode change, and supports freezing.
module ssd_source_select
    import ssd_source_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SAMPLE_CYCLES   = 25000000,
    parameter int CNT_W           = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              freeze,
    input  logic [31:0]       src_pc,
    input  logic [31:0]       src_alu,
    input  logic [31:0]       src_inst,
    input  logic [31:0]       src_reg,
    output logic [DISP_W-1:0] num,
    output logic [1:0]        mode,
    output logic              ovf
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_CYCLES - 1);

    logic             press;
    logic             press_d;
    logic             frz_s1;
    logic             frz_s2;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             load;
    mode_e            mode_q;
    logic [31:0]      sel;
    disp_t            disp_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_next),
        .press (press)
    );

    assign tick = (tick_cnt == TICK_LAST);
    // press_d trails the mode update by one cycle so the load sees the new source.
    assign load = tick | press_d;

    always_comb begin
        sel = src_pc;
        case (mode_q)
            MODE_PC:   sel = src_pc;
            MODE_ALU:  sel = src_alu;
            MODE_INST: sel = src_inst;
            MODE_REG:  sel = src_reg;
            default:   sel = src_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frz_s1   <= 1'b0;
            frz_s2   <= 1'b0;
            press_d  <= 1'b0;
            tick_cnt <= '0;
            mode_q   <= MODE_PC;
            disp_q   <= '0;
        end else begin
            frz_s1  <= freeze;
            frz_s2  <= frz_s1;
            press_d <= press;

            if (tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end

            if (press) begin
                mode_q <= mode_e'(mode_q + 2'd1);
            end

            if (load && !frz_s2) begin
                disp_q <= saturate(sel);
            end
        end
    end

    assign num  = disp_q.num;
    assign ovf  = disp_q.ovf;
    assign mode = mode_q;

endmodule

// File: doc/ssd_source_select.md
Name: ssd_source_select

Overview:
- Upstream feeder for the four-digit seven-segment driver: produces its 13-bit binary `num` input.
- Picks one of four processor observation values (PC, ALU result, instruction, register read data) with a debounced push-button.
- Samples the chosen value at a human-readable rate, saturates it to the 13-bit display range, and supports freezing the display.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable cycles needed before a button level change is accepted (10 ms at 100 MHz).
- SAMPLE_CYCLES, 25000000, clock cycles between periodic display refresh samples (250 ms at 100 MHz).
- CNT_W, 25, width of the debounce and sample counters; must hold max(DEBOUNCE_CYCLES, SAMPLE_CYCLES).

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_next  in  1  raw push-button, asynchronous, bouncy, active-high.
- freeze  in  1  slide switch, asynchronous; 1 = hold displayed value.
- src_pc  in  32  current PC.
- src_alu  in  32  ALU result.
- src_inst  in  32  current instruction word.
- src_reg  in  32  register-file read data.
- num  out  13  value to the seven-segment driver.
- mode  out  2  selected source: 0 = PC, 1 = ALU, 2 = INST, 3 = REG (drives status LEDs).
- ovf  out  1  1 when the selected source exceeded 8191 at the last sample.

Behaviour:
- Clock and reset: one clock `clk`; `rst_n` is asynchronous and active-low.
- Reset values: num = 0, mode = 0, ovf = 0, debounced button level = 0, counters = 0, synchronizer flops = 0.
- Input synchronization: `btn_next` and `freeze` each pass through a 2-flop synchronizer before any use.
- Debounce:
  - Counter clears whenever the synchronized button equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - Bounces shorter than DEBOUNCE_CYCLES produce no change.
- Press detect: a one-cycle `press` pulse occurs on the 0->1 transition of the debounced level only. A release produces nothing.
- Mode:
  - On `press`, mode <= mode + 1, wrapping 3 -> 0. Mode advances even while frozen.
- Sample tick counter:
  - Free-running 0..SAMPLE_CYCLES-1.
  - `tick` is asserted on the cycle it equals SAMPLE_CYCLES-1; the counter then wraps to 0.
- Load event: `load = tick | press_d`, where `press_d` is `press` delayed one cycle. The delay lets the new mode take effect before sampling.
- Sampling, on load while synchronized freeze = 0:
  - sel = source chosen by the current mode (value after any mode update).
  - If sel[31:13] != 0: num <= 13'd8191 and ovf <= 1.
  - Else: num <= sel[12:0] and ovf <= 0.
  - Source values are treated as unsigned.
- Freeze:
  - While synchronized freeze = 1, num and ovf hold.
  - After freeze is deasserted, the first load updates them.
- Latency:
  - Button: debounced press edge -> mode update, 1 cycle; -> num update, 2 cycles.
  - Freeze: raw freeze change takes effect 2 cycles later through the synchronizer.
- Simultaneous events:
  - If tick and press_d coincide, a single load occurs; no double update.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), including a partially counted debounce.
- No combinational path from any input to num, mode or ovf; all three are registered.

Decomposition:
- Shared display package:
  - mode encodings MODE_PC = 2'd0, MODE_ALU = 2'd1, MODE_INST = 2'd2, MODE_REG = 2'd3.
  - DISP_W = 13 and DISP_MAX = 13'd8191, shared with the seven-segment driver.
- One natural sub-module: `btn_debounce`.
  - Contains the synchronizer, debounce counter and rising-edge pulse.
  - Parameterized by DEBOUNCE_CYCLES; reusable for other board buttons.
- The freeze synchronizer stays inline.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4 and SAMPLE_CYCLES = 16.
- Reset then run: src_pc = 32'd1234 -> num = 0 and mode = 0 during reset; num = 1234 after the first tick (cycle 16); ovf = 0.
- Bounce rejection: btn_next toggled 0/1 with 3-cycle periods for 30 cycles, then held 1 -> exactly one mode increment (0 -> 1); num = src_alu (e.g. 77) 2 cycles after the debounced edge.
- Wrap and saturation: four clean presses with src_inst = 32'h0000_2000 -> mode goes 1, 2, 3, 0; in mode 2 num = 8191 and ovf = 1; returning to a source of 500 gives num = 500, ovf = 0.
- Freeze: freeze = 1, then src_pc changes 1234 -> 42 over 3 ticks -> num stays 1234; freeze = 0 -> num = 42 at the next tick.
- Coincidence: press_d aligned with a tick cycle -> a single load occurs with the new mode's source; the tick counter phase is unchanged.
- Async reset mid-debounce: assert rst_n = 0 after 2 of 4 stable button cycles -> outputs zero immediately; after release with the button held, a full 4 stable cycles are required before the mode changes.
